// File: rtl/if_prefetch_unit.sv
// Instruction-fetch controller: owns the PC, runs the MAR/mem_en/MFC read handshake,
// buffers fetched words in a DEPTH-entry queue drained by the decoder, supports redirect and MFC timeout.
module if_prefetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter int                 DATA_W   = 16,
  parameter int                 DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_rw,
  output logic              mar_en,
  input  logic              mfc,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_val,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_REQ, S_FAULT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [ADDR_W-1:0] r_fault_addr;
  logic [WW-1:0]     r_wait;
  logic              r_mem_en;
  logic              r_mar_en;
  logic              r_fault;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [ADDR_W-1:0] r_q_pc   [DEPTH];

  logic              w_pop;
  logic              w_push;
  logic [CW-1:0]     w_wr_idx;

  assign w_pop    = (r_count != '0) && instr_ready;
  assign w_push   = (r_state == S_REQ) && mfc;
  assign w_wr_idx = w_pop ? (r_count - CW'(1)) : r_count;

  // Fetch FSM: a fetch starts only when a queue slot is guaranteed, so at most one is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_mar        <= '0;
      r_wait       <= '0;
      r_mem_en     <= 1'b0;
      r_mar_en     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (pc_load) begin
      r_state  <= S_IDLE;
      r_pc     <= pc_load_val;
      r_wait   <= '0;
      r_mem_en <= 1'b0;
      r_mar_en <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_count < CW'(DEPTH)) || w_pop) begin
            r_state  <= S_ADDR;
            r_mar_en <= 1'b1;
          end
        end
        S_ADDR: begin
          r_mar    <= r_pc;
          r_mar_en <= 1'b0;
          r_mem_en <= 1'b1;
          r_state  <= S_REQ;
        end
        S_REQ: begin
          if (mfc) begin
            r_pc     <= r_pc + ADDR_W'(1);
            r_wait   <= '0;
            r_mem_en <= 1'b0;
            r_state  <= S_IDLE;
          end else if (r_wait == WW'(TIMEOUT - 1)) begin
            r_fault      <= 1'b1;
            r_fault_addr <= r_mar;
            r_wait       <= '0;
            r_mem_en     <= 1'b0;
            r_state      <= S_FAULT;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        S_FAULT: r_state <= S_FAULT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shift queue: entry 0 is always the head, so instr/instr_pc come straight from registers.
  always_ff @(posedge clk) begin
    if (rst || pc_load) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_data[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          r_q_data[i] <= r_q_data[i+1];
          r_q_pc[i]   <= r_q_pc[i+1];
        end
      end
      if (w_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == w_wr_idx) begin
            r_q_data[i] <= mem_data;
            r_q_pc[i]   <= r_mar;
          end
        end
      end
      if (w_push && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CW'(1);
    end
  end

  assign mem_addr    = r_mar;
  assign mem_en      = r_mem_en;
  assign mem_rw      = 1'b1;
  assign mar_en      = r_mar_en;
  assign instr       = r_q_data[0];
  assign instr_pc    = r_q_pc[0];
  assign instr_valid = (r_count != '0);
  assign fault       = r_fault;
  assign fault_addr  = r_fault_addr;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: cycle table for the first fetches, scoreboard of fetched words,
// and directed sequences for back-pressure, timeout, redirect, reset mid-fetch and PC wrap.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_addr, instr, instr_pc, fault_addr;
  logic        mem_en, mem_rw, mar_en, instr_valid, fault;
  logic        mfc = 1'b0;
  logic [15:0] mem_data = 16'h0;
  logic        instr_ready = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_val = 16'h0;

  logic [15:0] mem_addr1, instr1, instr_pc1, fault_addr1;
  logic        mem_en1, mem_rw1, mar_en1, instr_valid1, fault1;
  logic        mfc1 = 1'b0;
  logic [15:0] mem_data1 = 16'h0;
  logic        ready1 = 1'b1;
  logic        pc_load1 = 1'b0;
  logic [15:0] pc_load_val1 = 16'h0;

  always #5 clk = ~clk;

  if_prefetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(2), .RESET_PC(16'h0000), .TIMEOUT(15)) u0 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_en(mem_en), .mem_rw(mem_rw), .mar_en(mar_en),
    .mfc(mfc), .mem_data(mem_data), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc_load(pc_load), .pc_load_val(pc_load_val), .fault(fault),
    .fault_addr(fault_addr));

  if_prefetch_unit #(.ADDR_W(16), .DATA_W(16), .DEPTH(2), .RESET_PC(16'hFFFF), .TIMEOUT(15)) u1 (
    .clk(clk), .rst(rst), .mem_addr(mem_addr1), .mem_en(mem_en1), .mem_rw(mem_rw1), .mar_en(mar_en1),
    .mfc(mfc1), .mem_data(mem_data1), .instr(instr1), .instr_pc(instr_pc1), .instr_valid(instr_valid1),
    .instr_ready(ready1), .pc_load(pc_load1), .pc_load_val(pc_load_val1), .fault(fault1),
    .fault_addr(fault_addr1));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  typedef struct { logic [15:0] pc; logic [15:0] data; } exp_t;
  exp_t        sbq[$];
  logic [15:0] exp_pc = 16'h0;
  int          n_fetch = 0;
  logic        auto_mfc = 1'b0;
  logic [31:0] u1_log[$];

  // Memory model and scoreboard, evaluated away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    mfc       = auto_mfc && mem_en;
    mem_data  = 16'hA000 + mem_addr;
    mfc1      = mem_en1;
    mem_data1 = 16'hA000 + mem_addr1;
    if (!rst && instr_valid1 && u1_log.size() < 2)
      u1_log.push_back({instr_pc1, instr1});
    if (rst) begin
      sbq.delete();
      exp_pc = 16'h0000;
    end else if (pc_load) begin
      sbq.delete();
      exp_pc = pc_load_val;
    end else begin
      if (instr_valid && instr_ready) begin
        chk("sb_nonempty_on_pop", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("pop_instr", instr, e.data);
          chk("pop_instr_pc", instr_pc, e.pc);
        end
      end
      if (mfc) begin
        chk("req_addr", mem_addr, exp_pc);
        e.pc   = exp_pc;
        e.data = 16'hA000 + exp_pc;
        sbq.push_back(e);
        exp_pc = exp_pc + 16'h1;
        n_fetch++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        valid;
    logic        en;
    logic        mar;
    logic [15:0] addr;
    logic [15:0] ipc;
  } row_t;
  row_t tbl[9];

  initial begin
    int k;
    int base;
    logic [15:0] req_addr;

    // edges 1..9 after reset release, decoder always ready, mfc in first REQ cycle
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0000};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h0000};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0002};

    tick();
    tick();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mar_en", mar_en, 0);
    chk("rst_mem_rw", mem_rw, 1);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fault_addr", fault_addr, 0);
    chk("rst_mem_addr", mem_addr, 0);

    rst = 1'b0;
    auto_mfc = 1'b1;
    for (int i = 0; i < 9; i++) begin
      instr_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i + 1), instr_valid, tbl[i].valid);
      chk($sformatf("tbl%0d_mem_en", i + 1), mem_en, tbl[i].en);
      chk($sformatf("tbl%0d_mar_en", i + 1), mar_en, tbl[i].mar);
      chk($sformatf("tbl%0d_mem_addr", i + 1), mem_addr, tbl[i].addr);
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_instr_pc", i + 1), instr_pc, tbl[i].ipc);
        chk($sformatf("tbl%0d_instr", i + 1), instr, 16'hA000 + tbl[i].ipc);
      end
    end

    // back-pressure: one word already queued, so only one more fetch fills the queue
    instr_ready = 1'b0;
    base = n_fetch;
    repeat (10) tick();
    chk("park_fetches", n_fetch - base, 1);
    chk("park_mem_en", mem_en, 0);
    chk("park_mar_en", mar_en, 0);
    chk("park_valid", instr_valid, 1);
    chk("park_sb_size", sbq.size(), 2);
    instr_ready = 1'b1;
    base = n_fetch;
    tick();
    instr_ready = 1'b0;
    repeat (10) tick();
    chk("onepop_fetches", n_fetch - base, 1);
    chk("onepop_mem_en", mem_en, 0);
    chk("onepop_sb_size", sbq.size(), 2);

    // MFC timeout
    auto_mfc = 1'b0;
    instr_ready = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!mem_en && k < 20);
    chk("t3_req_seen", mem_en, 1);
    req_addr = mem_addr;
    chk("t3_req_addr", req_addr, 16'h0005);
    k = 1;
    do begin tick(); if (mem_en) k++; end while (mem_en && k < 40);
    chk("t3_req_cycles", k, 15);
    chk("t3_fault", fault, 1);
    chk("t3_fault_addr", fault_addr, 16'h0005);
    repeat (3) tick();
    chk("t3_fault_mem_en", mem_en, 0);
    chk("t3_fault_mar_en", mar_en, 0);
    chk("t3_fault_sticky", fault, 1);

    // redirect out of FAULT
    auto_mfc = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 16'h0040;
    tick();
    pc_load = 1'b0;
    chk("t3_fault_cleared", fault, 0);
    chk("t3_flush_valid", instr_valid, 0);
    k = 0;
    do begin tick(); k++; end while (!mem_en && k < 10);
    chk("t3_redirect_lat", k, 2);
    chk("t3_redirect_addr", mem_addr, 16'h0040);

    // redirect colliding with mfc while one word queued and a fetch in REQ
    instr_ready = 1'b0;
    repeat (12) tick();
    chk("t4_full", sbq.size(), 2);
    auto_mfc = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!mem_en && k < 10);
    chk("t4_in_req", mem_en, 1);
    chk("t4_one_queued", instr_valid, 1);
    auto_mfc = 1'b1;
    pc_load = 1'b1;
    pc_load_val = 16'h1234;
    tick();
    pc_load = 1'b0;
    chk("t4_flush_valid", instr_valid, 0);
    chk("t4_flush_mem_en", mem_en, 0);
    instr_ready = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!instr_valid && k < 10);
    chk("t4_first_lat", k, 3);
    chk("t4_first_pc", instr_pc, 16'h1234);
    chk("t4_first_instr", instr, 16'hB234);

    // reset during REQ with one entry queued
    instr_ready = 1'b0;
    repeat (12) tick();
    auto_mfc = 1'b0;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    k = 0;
    do begin tick(); k++; end while (!mem_en && k < 10);
    chk("t6_in_req", mem_en, 1);
    chk("t6_one_queued", instr_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", instr_valid, 0);
    chk("t6_mem_en", mem_en, 0);
    auto_mfc = 1'b1;
    instr_ready = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!mem_en && k < 10);
    chk("t6_refetch_addr", mem_addr, 16'h0000);
    k = 0;
    do begin tick(); k++; end while (!instr_valid && k < 10);
    chk("t6_refetch_pc", instr_pc, 16'h0000);
    repeat (3) tick();

    // PC wrap on the RESET_PC=0xFFFF instance
    chk("wrap_log_size", u1_log.size(), 2);
    if (u1_log.size() == 2) begin
      chk("wrap_pc0", u1_log[0], {16'hFFFF, 16'h9FFF});
      chk("wrap_pc1", u1_log[1], {16'h0000, 16'hA000});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule
